// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel counter, shadowed terminal count,
// registered square-wave and tick outputs, all from the single clk_in domain.
module clk_div_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 17,
  parameter int unsigned DEFAULT_DIV = 49999,
  parameter int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] sync_clr,
  input  logic              div_load,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_q, act_d;
    logic [CNT_W-1:0] shd_q, shd_d;
    logic [CNT_W-1:0] apply_val;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             pend_q, pend_d;
    logic             load_hit;
    logic             at_term;

    // Out-of-range div_ch never matches any channel index, so it is silently dropped.
    assign load_hit = div_load && (div_ch == CH_W'(gi));
    assign at_term  = (cnt_q == act_q);

    // A load landing on the same edge as a wrap/clear takes effect immediately.
    assign apply_val = load_hit ? div_val : (pend_q ? shd_q : act_q);

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = load_hit ? div_val : shd_q;
      clk_d  = clk_q;
      tick_d = 1'b0;
      pend_d = pend_q | load_hit;
      if (sync_clr[gi]) begin
        cnt_d  = '0;
        clk_d  = 1'b0;
        act_d  = apply_val;
        pend_d = 1'b0;
      end else if (en[gi]) begin
        if (at_term) begin
          cnt_d  = '0;
          clk_d  = ~clk_q;
          tick_d = 1'b1;
          act_d  = apply_val;
          pend_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        act_q  <= DefDiv;
        shd_q  <= DefDiv;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
        pend_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
        pend_q <= pend_d;
      end
    end

    assign clk_out[gi] = clk_q;
    assign tick[gi]    = tick_q;
    assign pend[gi]    = pend_q;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: default divide, shadow loads, enable gating,
// synchronous clear, out-of-range loads and asynchronous reset.
module tb_clk_div_multi;
  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned CNT_W       = 17;
  localparam int unsigned DEFAULT_DIV = 49999;
  localparam int unsigned CH_W        = 3;

  logic              clk_in = 1'b0;
  logic              rst_n  = 1'b1;
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] sync_clr;
  logic              div_load;
  logic [CH_W-1:0]   div_ch;
  logic [CNT_W-1:0]  div_val;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pend;

  int n_checks = 0;
  int n_pass   = 0;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .CH_W        (CH_W)
  ) u_dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .en       (en),
    .sync_clr (sync_clr),
    .div_load (div_load),
    .div_ch   (div_ch),
    .div_val  (div_val),
    .clk_out  (clk_out),
    .tick     (tick),
    .pend     (pend)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic load(input int ch, input int val);
    div_load = 1'b1;
    div_ch   = ch[CH_W-1:0];
    div_val  = val[CNT_W-1:0];
    step();
    div_load = 1'b0;
  endtask

  initial begin
    logic ok;
    en       = '0;
    sync_clr = '0;
    div_load = 1'b0;
    div_ch   = '0;
    div_val  = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_clk_out", 32'(clk_out), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_pend", 32'(pend), 0);
    repeat (3) step();
    rst_n = 1'b1;
    en    = 4'b0001;

    // Default divisor: first tick after edge 50000
    repeat (49999) step();
    check("def_pre_tick", 32'(tick), 0);
    check("def_pre_clk", 32'(clk_out), 0);
    step();
    check("def_tick", 32'(tick), 1);
    check("def_clk", 32'(clk_out), 1);
    step();
    check("def_tick_off", 32'(tick), 0);
    check("def_clk_hold", 32'(clk_out), 1);

    // Channel 0, T=4, enable dropped for 7 cycles at cnt=2
    load(0, 4);
    check("a_pend", 32'(pend), 1);
    sync_clr = 4'b0001;
    step();
    sync_clr = '0;
    check("a_clr_clk", 32'(clk_out), 0);
    check("a_clr_pend", 32'(pend), 0);
    step();
    step();
    en[0] = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (tick != 4'b0000 || clk_out != 4'b0000) ok = 1'b0;
    end
    check("a_frozen", 32'(ok), 1);
    en[0] = 1'b1;
    step();
    step();
    check("a_resume_early", 32'(tick[0]), 0);
    step();
    check("a_resume_tick", 32'(tick[0]), 1);
    check("a_resume_clk", 32'(clk_out[0]), 1);

    // Channel 1, T=3, reload T=1 at cnt=1
    load(1, 3);
    sync_clr = 4'b0010;
    en[1]    = 1'b1;
    step();
    sync_clr = '0;
    step();
    load(1, 1);
    check("b_pend_set", 32'(pend[1]), 1);
    check("b_tick_e2", 32'(tick[1]), 0);
    step();
    check("b_tick_e3", 32'(tick[1]), 0);
    check("b_pend_hold", 32'(pend[1]), 1);
    step();
    check("b_wrap_tick", 32'(tick[1]), 1);
    check("b_wrap_pend", 32'(pend[1]), 0);
    check("b_wrap_clk", 32'(clk_out[1]), 1);
    step();
    check("b_new_gap", 32'(tick[1]), 0);
    step();
    check("b_new_tick", 32'(tick[1]), 1);
    check("b_new_clk", 32'(clk_out[1]), 0);

    // Channel 2, T=5, load T=2 coinciding with wrap
    load(2, 5);
    sync_clr = 4'b0100;
    en[2]    = 1'b1;
    step();
    sync_clr = '0;
    repeat (5) step();
    check("c_pre_wrap", 32'(tick[2]), 0);
    load(2, 2);
    check("c_wrap_tick", 32'(tick[2]), 1);
    check("c_wrap_pend", 32'(pend[2]), 0);
    check("c_wrap_clk", 32'(clk_out[2]), 1);
    ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (tick[2] != 1'b0 || pend[2] != 1'b0) ok = 1'b0;
    end
    check("c_gap", 32'(ok), 1);
    step();
    check("c_tick3", 32'(tick[2]), 1);
    check("c_clk3", 32'(clk_out[2]), 0);

    // Channel 2, T=0: tick constant, clk_out toggles each cycle
    load(2, 0);
    sync_clr = 4'b0100;
    step();
    sync_clr = '0;
    check("t0_clr_clk", 32'(clk_out[2]), 0);
    check("t0_clr_pend", 32'(pend[2]), 0);
    step();
    check("t0_tick1", 32'(tick[2]), 1);
    check("t0_clk1", 32'(clk_out[2]), 1);
    step();
    check("t0_tick2", 32'(tick[2]), 1);
    check("t0_clk2", 32'(clk_out[2]), 0);

    // Channels 0 and 3 at T=9, skewed, then cleared together
    load(0, 9);
    load(3, 9);
    sync_clr = 4'b1001;
    en[3]    = 1'b1;
    step();
    sync_clr = '0;
    en[3]    = 1'b0;
    repeat (3) step();
    en[3] = 1'b1;
    repeat (4) step();
    sync_clr = 4'b1001;
    step();
    sync_clr = '0;
    check("d_clr_clk", 32'({clk_out[3], clk_out[0]}), 0);
    check("d_clr_tick", 32'({tick[3], tick[0]}), 0);
    load(5, 7);
    check("d_bad_ch_pend", 32'(pend), 0);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tick[0] || tick[3] || clk_out[0] != clk_out[3]) ok = 1'b0;
    end
    check("d_phase_gap", 32'(ok), 1);
    step();
    check("d_tick_pair", 32'({tick[3], tick[0]}), 3);
    check("d_clk_pair", 32'({clk_out[3], clk_out[0]}), 3);
    ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (tick[0] || tick[3]) ok = 1'b0;
    end
    check("d_period_gap", 32'(ok), 1);
    step();
    check("d_tick_pair2", 32'({tick[3], tick[0]}), 3);
    check("d_clk_pair2", 32'({clk_out[3], clk_out[0]}), 0);

    // Asynchronous reset mid-period with a pending load
    load(1, 6);
    check("e_pend_before", 32'(pend[1]), 1);
    #3 rst_n = 1'b0;
    #1;
    check("e_async_clk", 32'(clk_out), 0);
    check("e_async_tick", 32'(tick), 0);
    check("e_async_pend", 32'(pend), 0);
    #20;
    step();
    rst_n = 1'b1;
    en    = 4'b0011;
    ok    = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (tick != 4'b0000 || pend != 4'b0000 || clk_out != 4'b0000) ok = 1'b0;
    end
    check("e_default_restored", 32'(ok), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4: number of independent divider channels, range 1..16.
REQ-002 The block SHALL have parameter CNT_W, default 17: width of each channel counter and divisor.
REQ-003 The block SHALL have parameter DEFAULT_DIV, default 49999: terminal count loaded into every channel at reset (1 kHz square from 100 MHz).
REQ-004 The block SHALL have parameter CH_W, default max(1, clog2(NUM_CH)): channel-index width.
REQ-005 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port en, input, NUM_CH bits: per-channel count enable.
REQ-008 The block SHALL have port sync_clr, input, NUM_CH bits: per-channel synchronous phase clear.
REQ-009 The block SHALL have port div_load, input, 1 bit: one-cycle write strobe for a new terminal count.
REQ-010 The block SHALL have port div_ch, input, CH_W bits: target channel of div_load.
REQ-011 The block SHALL have port div_val, input, CNT_W bits: new terminal count T.
REQ-012 The block SHALL have port clk_out, output, NUM_CH bits: per-channel registered square wave.
REQ-013 The block SHALL have port tick, output, NUM_CH bits: per-channel registered one-cycle pulse.
REQ-014 The block SHALL have port pend, output, NUM_CH bits: per channel, high while a loaded divisor awaits application.

Function
REQ-015 Each channel SHALL hold a counter cnt, an active terminal count act, a shadow terminal count shd, and pend.
REQ-016 With en[i]=1, cnt[i] SHALL increment by 1 each cycle; when cnt[i]==act[i] it SHALL wrap to 0 on the next edge (a "wrap").
REQ-017 On each wrap, clk_out[i] SHALL toggle and tick[i] SHALL be 1 for exactly that one following cycle; tick period = T+1 cycles, clk_out period = 2(T+1) cycles, 50% duty.
REQ-018 T=0 SHALL be legal: tick[i] constant 1 while enabled, clk_out[i] toggles every cycle.
REQ-019 With en[i]=0, cnt[i] and clk_out[i] SHALL hold and tick[i] SHALL be 0; re-enable SHALL resume from the held count with no extra or lost count.
REQ-020 div_load=1 SHALL write div_val into shd[div_ch] and set pend[div_ch] on the next edge; div_ch >= NUM_CH SHALL be ignored with no state change.
REQ-021 At the next wrap of a channel with pend=1, act SHALL take shd and pend SHALL clear; the current period always completes with the old T (glitch-free).
REQ-022 If div_load targets a channel in the same cycle as its wrap, the new value SHALL be applied at that wrap and pend SHALL end 0.
REQ-023 A second load before application SHALL overwrite shd; only the last value is applied.
REQ-024 sync_clr[i]=1 SHALL on the next edge set cnt[i]=0, clk_out[i]=0, tick[i]=0, apply a pending shd to act, clear pend[i]; sync_clr has priority over en and wrap.
REQ-025 Channels SHALL be fully independent; activity on one SHALL not alter any other.
REQ-026 All outputs SHALL be direct register outputs; no combinational path from inputs to outputs.

Reset
REQ-027 rst_n=0 SHALL immediately, regardless of clk_in, set every cnt=0, act=shd=DEFAULT_DIV, clk_out=0, tick=0, pend=0.
REQ-028 Reset asserted mid-period or with a pending load SHALL discard that load; counting SHALL begin on the first rising edge after rst_n rises, with en high.

Verification
REQ-029 Reset release, en=4'b0001, DEFAULT_DIV=49999 -> tick[0] every 50000 cycles, clk_out[0] period 100000 cycles, channels 1-3 static 0.
REQ-030 Channel 1 with T=3, load T=1 at cnt=1 -> pend[1]=1, current period still 4 cycles, subsequent ticks every 2 cycles, pend[1]=0 after the wrap.
REQ-031 div_load on channel 2 coinciding with its wrap, T 5->2 -> next period is 3 cycles, pend[2] never observed high after the edge.
REQ-032 Channel 0 T=4, drop en for 7 cycles at cnt=2 -> tick/clk_out frozen, tick resumes exactly 3 cycles after en returns.
REQ-033 sync_clr on channels 0 and 3 while running T=9 -> both clk_out=0 and cnt=0 next cycle, thereafter identical phase; load with div_ch=5 (NUM_CH=4) -> no change.
REQ-034 rst_n pulsed low asynchronously mid-period with pend=1 -> all outputs 0 without a clock edge, act back to DEFAULT_DIV, pend=0.
